// File: rtl/telemetry_scheduler.sv
// Samples three counter channels on a fixed period, clears them, and streams each
// snapshot to the byte-wide UART as an 8-byte frame (header word, then channels 1..3).
//   state | meaning
//   IDLE  | waiting for a pending snapshot
//   LOAD  | copy snapshot into the frame buffer
//   SEND  | issue START as soon as the UART is free
//   GAP   | hold off BYTE_GAP cycles before the next byte
module telemetry_scheduler #(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned BYTE_GAP      = 5000,
    parameter logic [15:0] HEADER        = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] result1,
    input  logic [15:0] result2,
    input  logic [15:0] result3,
    input  logic        uart_busy,
    output logic        rst_count1,
    output logic        rst_count2,
    output logic        rst_count3,
    output logic [7:0]  UARTDATA,
    output logic        START,
    output logic        frame_done,
    output logic        overrun
);
    localparam int SW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(BYTE_GAP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
    state_t state, state_nxt;

    logic [SW-1:0] sample_cnt;
    logic          tick;
    logic [15:0]   snap1, snap2, snap3;
    logic          pending;
    logic          clr_q;
    logic          overrun_q;
    logic [63:0]   frame_buf;
    logic [3:0]    idx;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    data_q;
    logic [7:0]    cur_byte;
    logic          load;
    logic          start;
    logic          done;

    assign tick     = (sample_cnt == SAMPLE_LAST);
    assign cur_byte = frame_buf[{idx[2:0], 3'b000} +: 8];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sample_cnt <= '0;
            snap1      <= '0;
            snap2      <= '0;
            snap3      <= '0;
            pending    <= 1'b0;
            clr_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sample_cnt <= tick ? '0 : sample_cnt + SW'(1);
            clr_q      <= tick;
            if (tick) begin
                snap1 <= result1;
                snap2 <= result2;
                snap3 <= result3;
            end
            // A tick landing on LOAD re-arms pending with fresher data; nothing is lost.
            if (tick)
                pending <= 1'b1;
            else if (load)
                pending <= 1'b0;
            if (tick && pending && !load)
                overrun_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (pending) state_nxt = LOAD;
            LOAD: begin
                load      = 1'b1;
                state_nxt = SEND;
            end
            SEND: if (!uart_busy) begin
                start     = 1'b1;
                state_nxt = GAP;
            end
            GAP: if (gap_cnt == GAP_LAST) begin
                if (idx == 4'd8) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SEND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            frame_buf <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            data_q    <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                frame_buf <= {snap3, snap2, snap1, HEADER};
                idx       <= '0;
            end else if (start) begin
                idx <= idx + 4'd1;
            end
            if (start) begin
                gap_cnt <= GW'(1);
                data_q  <= cur_byte;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    assign rst_count1 = clr_q;
    assign rst_count2 = clr_q;
    assign rst_count3 = clr_q;
    assign START      = start;
    assign UARTDATA   = start ? cur_byte : data_q;
    assign frame_done = done;
    assign overrun    = overrun_q;
endmodule
